// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel interval timer.
// Channel state encoding used by every timer_channel instance.
package multi_timer_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } ch_state_e;

endpackage

// File: rtl/timer_channel.sv
// One independent timer channel: latches its configuration on start and steps on the shared tick.
// Terminal count is checked before stepping, so the count never wraps.
module timer_channel
   import multi_timer_pkg::*;
#(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             start,
   input  logic             clear,
   input  logic             pause,
   input  logic             dir,
   input  logic             periodic,
   input  logic [CNT_W-1:0] interval,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             timeout
);

   ch_state_e        state_q;
   logic             dir_q;
   logic             periodic_q;
   logic [CNT_W-1:0] interval_q;
   logic [CNT_W-1:0] count_q;
   logic             busy_q;
   logic             done_q;
   logic             timeout_q;
   logic [CNT_W-1:0] term;
   logic [CNT_W-1:0] reload;

   always_comb begin
      term   = dir_q ? interval_q : '0;
      reload = dir_q ? '0 : interval_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         dir_q      <= 1'b0;
         periodic_q <= 1'b0;
         interval_q <= '0;
         count_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         if (clear) begin
            state_q <= StIdle;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else if (start) begin
            // A tick coinciding with start is deliberately dropped.
            dir_q      <= dir;
            periodic_q <= periodic;
            interval_q <= interval;
            count_q    <= dir ? '0 : interval;
            state_q    <= StRun;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
         end else if (state_q == StRun && tick && !pause) begin
            if (count_q == term) begin
               timeout_q <= 1'b1;
               if (periodic_q) begin
                  count_q <= reload;
               end else begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end else begin
               count_q <= dir_q ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
            end
         end
      end
   end

   assign count   = count_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign timeout = timeout_q;

endmodule

// File: rtl/multi_interval_timer.sv
// N_CH independent interval timers sharing one free-running prescaler tick.
// The prescaler divides clk by CLOCK_FREQ/TICK_HZ and is cleared only by rst.
module multi_interval_timer
   import multi_timer_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 50_000,
   parameter int unsigned TICK_HZ    = 1,
   parameter int unsigned CNT_W      = 4,
   parameter int unsigned N_CH       = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       start,
   input  logic [N_CH-1:0]       clear,
   input  logic [N_CH-1:0]       pause,
   input  logic [N_CH-1:0]       dir,
   input  logic [N_CH-1:0]       periodic,
   input  logic [N_CH*CNT_W-1:0] interval,
   output logic [N_CH*CNT_W-1:0] count,
   output logic [N_CH-1:0]       busy,
   output logic [N_CH-1:0]       done,
   output logic [N_CH-1:0]       timeout,
   output logic                  tick
);

   localparam int unsigned Div  = CLOCK_FREQ / TICK_HZ;
   localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;

   logic [DivW-1:0] div_q;
   logic            tick_int;

   assign tick_int = (div_q == DivW'(Div - 1));
   assign tick     = tick_int;

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
      end else if (tick_int) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DivW'(1);
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      timer_channel #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .tick     (tick_int),
         .start    (start[i]),
         .clear    (clear[i]),
         .pause    (pause[i]),
         .dir      (dir[i]),
         .periodic (periodic[i]),
         .interval (interval[i*CNT_W +: CNT_W]),
         .count    (count[i*CNT_W +: CNT_W]),
         .busy     (busy[i]),
         .done     (done[i]),
         .timeout  (timeout[i])
      );
   end

endmodule

// File: tb/tb_multi_interval_timer.sv
// Bench for multi_interval_timer: directed scenarios push expected timeout events into a
// scoreboard queue; a negedge monitor pops and compares each timeout pulse it sees.
module tb_multi_interval_timer;

   localparam int unsigned CLOCK_FREQ = 10;
   localparam int unsigned TICK_HZ    = 1;
   localparam int unsigned CNT_W      = 4;
   localparam int unsigned N_CH       = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N_CH-1:0]       start;
   logic [N_CH-1:0]       clear;
   logic [N_CH-1:0]       pause;
   logic [N_CH-1:0]       dir;
   logic [N_CH-1:0]       periodic;
   logic [N_CH*CNT_W-1:0] interval;
   logic [N_CH*CNT_W-1:0] count;
   logic [N_CH-1:0]       busy;
   logic [N_CH-1:0]       done;
   logic [N_CH-1:0]       timeout;
   logic                  tick;

   multi_interval_timer #(
      .CLOCK_FREQ (CLOCK_FREQ),
      .TICK_HZ    (TICK_HZ),
      .CNT_W      (CNT_W),
      .N_CH       (N_CH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .clear    (clear),
      .pause    (pause),
      .dir      (dir),
      .periodic (periodic),
      .interval (interval),
      .count    (count),
      .busy     (busy),
      .done     (done),
      .timeout  (timeout),
      .tick     (tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int tick_no;
      int cnt;
      int dn;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   tick_cnt = 0;
   int   cyc      = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tick) tick_cnt <= tick_cnt + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int cnt_of(input int ch);
      return int'(count[ch*CNT_W +: CNT_W]);
   endfunction

   task automatic push_exp(input int ch, input int tk, input int c, input int d);
      exp_t e;
      e.ch      = ch;
      e.tick_no = tk;
      e.cnt     = c;
      e.dn      = d;
      sb_q.push_back(e);
   endtask

   // Every timeout pulse must match the next queued expectation.
   always @(negedge clk) begin
      exp_t e;
      for (int i = 0; i < int'(N_CH); i++) begin
         if (timeout[i]) begin
            if (sb_q.size() == 0) begin
               chk($sformatf("stray_timeout_ch%0d", i), int'(timeout[i]), 0);
            end else begin
               e = sb_q.pop_front();
               chk("to_channel", i, e.ch);
               chk($sformatf("to_tick_ch%0d", i), tick_cnt, e.tick_no);
               chk($sformatf("to_count_ch%0d", i), cnt_of(i), e.cnt);
               chk($sformatf("to_done_ch%0d", i), int'(done[i]), e.dn);
            end
         end
      end
   end

   // Returns one cycle after a tick edge, #1 past the clock edge.
   task automatic sync_tick();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tick && n < 40);
      if (!tick) chk("tick_wait", int'(tick), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [N_CH-1:0] m);
      start = m;
      @(posedge clk);
      #1;
      start = '0;
   endtask

   task automatic set_cfg(input int ch, input logic d, input logic p, input logic [CNT_W-1:0] iv);
      dir[ch]                    = d;
      periodic[ch]               = p;
      interval[ch*CNT_W +: CNT_W] = iv;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected to finish");
      $fatal(1);
   end

   initial begin
      int k;
      int c0;
      int seq[6] = '{1, 0, 2, 1, 0, 2};
      rst      = 1'b1;
      start    = '0;
      clear    = '0;
      pause    = '0;
      dir      = '0;
      periodic = '0;
      interval = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_count", int'(count), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_tick", int'(tick), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Tick period
      sync_tick();
      c0 = cyc;
      sync_tick();
      chk("tick_period", cyc - c0, 10);

      // Ch0 up one-shot interval 3; later config changes must not matter
      sync_tick();
      k = tick_cnt;
      set_cfg(0, 1'b1, 1'b0, 4'd3);
      pulse_start(4'b0001);
      chk("ch0_load", cnt_of(0), 0);
      chk("ch0_busy", int'(busy[0]), 1);
      push_exp(0, k + 4, 3, 1);
      set_cfg(0, 1'b0, 1'b1, 4'd9);
      for (int j = 1; j <= 3; j++) begin
         sync_tick();
         chk($sformatf("ch0_step%0d", j), cnt_of(0), j);
      end
      sync_tick();
      chk("ch0_done", int'(done[0]), 1);
      chk("ch0_busy_end", int'(busy[0]), 0);
      sync_tick();
      chk("ch0_hold", cnt_of(0), 3);

      // Ch1 down periodic interval 2
      sync_tick();
      k = tick_cnt;
      set_cfg(1, 1'b0, 1'b1, 4'd2);
      pulse_start(4'b0010);
      chk("ch1_load", cnt_of(1), 2);
      push_exp(1, k + 3, 2, 0);
      push_exp(1, k + 6, 2, 0);
      for (int j = 0; j < 6; j++) begin
         sync_tick();
         chk($sformatf("ch1_seq%0d", j), cnt_of(1), seq[j]);
         chk($sformatf("ch1_busy%0d", j), int'(busy[1]), 1);
      end
      clear[1] = 1'b1;
      @(posedge clk);
      #1;
      clear[1] = 1'b0;
      chk("ch1_clear_count", cnt_of(1), 0);
      chk("ch1_clear_busy", int'(busy[1]), 0);

      // Ch2 up interval 5, pause for 25 clocks masks two ticks
      sync_tick();
      k = tick_cnt;
      set_cfg(2, 1'b1, 1'b0, 4'd5);
      pulse_start(4'b0100);
      push_exp(2, k + 8, 5, 1);
      sync_tick();
      sync_tick();
      chk("ch2_prepause", cnt_of(2), 2);
      pause[2] = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      pause[2] = 1'b0;
      chk("ch2_frozen", cnt_of(2), 2);
      for (int j = 0; j < 3; j++) sync_tick();
      chk("ch2_pre_to", cnt_of(2), 5);
      sync_tick();
      chk("ch2_done", int'(done[2]), 1);

      // Ch3: start+clear together wins clear; restart during RUN reloads
      sync_tick();
      set_cfg(3, 1'b1, 1'b0, 4'd7);
      pulse_start(4'b1000);
      sync_tick();
      sync_tick();
      chk("ch3_run", cnt_of(3), 2);
      start[3] = 1'b1;
      clear[3] = 1'b1;
      @(posedge clk);
      #1;
      start[3] = 1'b0;
      clear[3] = 1'b0;
      chk("ch3_sc_count", cnt_of(3), 0);
      chk("ch3_sc_busy", int'(busy[3]), 0);
      sync_tick();
      chk("ch3_idle", int'(busy[3]), 0);
      set_cfg(3, 1'b1, 1'b0, 4'd4);
      pulse_start(4'b1000);
      sync_tick();
      sync_tick();
      chk("ch3_run2", cnt_of(3), 2);
      k = tick_cnt;
      pulse_start(4'b1000);
      chk("ch3_restart_count", cnt_of(3), 0);
      chk("ch3_restart_busy", int'(busy[3]), 1);
      push_exp(3, k + 5, 4, 1);
      for (int j = 0; j < 5; j++) sync_tick();
      chk("ch3_done", int'(done[3]), 1);

      // Interval 0, up on ch0 and down on ch1
      sync_tick();
      k = tick_cnt;
      set_cfg(0, 1'b1, 1'b0, 4'd0);
      set_cfg(1, 1'b0, 1'b0, 4'd0);
      pulse_start(4'b0011);
      push_exp(0, k + 1, 0, 1);
      push_exp(1, k + 1, 0, 1);
      sync_tick();
      chk("iv0_done", int'(done[1:0]), 3);

      // Reset while all channels run
      sync_tick();
      for (int i = 0; i < int'(N_CH); i++) set_cfg(i, 1'b1, 1'b1, 4'd15);
      pulse_start(4'b1111);
      sync_tick();
      sync_tick();
      chk("all_run", cnt_of(3), 2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_count", int'(count), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_timeout", int'(timeout), 0);
      chk("mid_rst_tick", int'(tick), 0);
      rst = 1'b0;
      for (int j = 0; j < 3; j++) sync_tick();
      chk("post_rst_busy", int'(busy), 0);

      chk("sb_empty", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
